// File: rtl/rr_arbiter8_pkg.sv
// Shared types and sizing for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

  localparam int N_REQ            = 8;
  localparam int IDX_W            = 3;
  localparam int MAX_HOLD_DEFAULT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_arbiter8_if;
  import rr_arbiter8_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             preempt;

  modport master (
    output req,
    input  grant, grant_idx, grant_valid, preempt
  );

  modport slave (
    input  req,
    output grant, grant_idx, grant_valid, preempt
  );

endinterface

// File: rtl/rr_arbiter8_decoder.sv
// 3-to-8 one-hot decoder with enable; output is all-zero when disabled.
module decoder
  import rr_arbiter8_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);

  // NOTE: assign a default first so no path through always_comb leaves onehot unassigned (no latch).
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a bounded hold time and forced release.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter8_if.slave bus
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] ptr;
  logic [7:0]       hold;
  logic             preempt_q;
  logic [N_REQ-1:0] grant;
  logic             others;

  // First set bit scanning ptr, ptr+1, ... (mod 8); descending loop leaves the nearest hit.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] c;
    pick = p;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      c = p + IDX_W'(k);
      if (r[c]) pick = c;
    end
    return pick;
  endfunction

  decoder u_decoder (
    .idx    (owner),
    .en     (state == BUSY),
    .onehot (grant)
  );

  // In BUSY the grant is the owner's bit, so anything left over is a competing request.
  assign others = |(bus.req & ~grant);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      hold      <= '0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state <= BUSY;
            owner <= rr_pick(bus.req, ptr);
            hold  <= '0;
          end
        end
        BUSY: begin
          if (!bus.req[owner]) begin
            state <= IDLE;
            ptr   <= owner + IDX_W'(1);
          end else if (hold == HOLD_LAST) begin
            // Saturated: keep the grant until somebody else asks.
            if (others) begin
              state     <= IDLE;
              ptr       <= owner + IDX_W'(1);
              preempt_q <= 1'b1;
            end
          end else begin
            hold <= hold + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant;
  assign bus.grant_idx   = owner;
  assign bus.grant_valid = (state == BUSY);
  assign bus.preempt     = preempt_q;

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter MAX_HOLD, default 16, is the maximum consecutive grant cycles before forced release when others wait; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req  input  8  request per requester; bit i high means requester i wants the shared resource.
REQ-005 grant  output  8  one-hot grant to the current owner; all-zero when no owner.
REQ-006 grant_idx  output  3  binary index of the current owner; holds the last owner when grant_valid is low.
REQ-007 grant_valid  output  1  high while an owner holds the resource.
REQ-008 preempt  output  1  one-cycle pulse in the cycle after a forced (timeout) release.

Function
REQ-009 The FSM SHALL have two states, IDLE and BUSY; all outputs SHALL be registered or decoded from registers only.
REQ-010 In IDLE with req != 0, the winner SHALL be the first set bit scanning ptr, ptr+1, ..., ptr+7 modulo 8, then go BUSY; grant_valid rises the cycle after req is sampled (1-cycle latency).
REQ-011 In IDLE with req == 0, the block SHALL stay in IDLE with grant_valid low.
REQ-012 In BUSY, the owner SHALL keep the grant while req[owner] stays high, subject to REQ-014.
REQ-013 In BUSY, if req[owner] is low, the block SHALL return to IDLE next cycle with grant cleared and ptr set to owner+1 mod 8 (wrap 7->0).
REQ-014 A hold counter SHALL reset to 0 on entry to BUSY and increment each BUSY cycle. When it equals MAX_HOLD-1 and any other req bit is high, the block SHALL force release: go to IDLE, set ptr to owner+1, and pulse preempt.
REQ-015 If the counter reaches MAX_HOLD-1 with no other requester, it SHALL saturate and the owner SHALL keep the grant; preemption occurs in the first later cycle another req appears.
REQ-016 Every release SHALL be followed by at least one cycle with grant_valid low before the next grant (release gap).
REQ-017 Owner drop and timeout in the same cycle SHALL count as a normal release: preempt stays low.
REQ-018 grant SHALL equal the 3-to-8 one-hot decode of grant_idx when grant_valid is high, else 8'h00; at most one grant bit is ever set.
REQ-019 Request bits toggling for non-owners during BUSY SHALL NOT affect the grant.

Reset
REQ-020 While rst is high at a rising edge: state = IDLE, grant = 8'h00, grant_idx = 0, grant_valid = 0, preempt = 0, ptr = 0, hold counter = 0.
REQ-021 Reset asserted mid-grant SHALL drop the grant on the next edge with no preempt pulse; arbitration after reset SHALL restart from ptr = 0.
REQ-022 The first arbitration is possible in the cycle after rst deasserts.

Structure
REQ-023 A shared package SHALL hold the state enum (IDLE, BUSY), N_REQ = 8, IDX_W = 3 and the default MAX_HOLD.
REQ-024 The one-hot grant SHALL come from one instance of the team's existing 3-to-8 sub-module "decoder" driven by grant_idx, gated by grant_valid.
REQ-025 The rotating priority search SHALL be a combinational function inside rr_arbiter8; there are no other sub-modules.

Verification
REQ-026 Reset then req = 8'b0000_0100 -> next cycle grant = 8'b0000_0100, grant_idx = 2, grant_valid = 1.
REQ-027 Owner 2 drops req with req = 8'b1000_0010 pending -> one idle cycle, then grant_idx = 7 (ptr = 3 scan), then after 7 releases grant_idx = 1 (wrap).
REQ-028 MAX_HOLD = 4, req = 8'h03 held -> owner 0 for 4 cycles, preempt pulse, one gap cycle, owner 1 for 4 cycles, then back to owner 0.
REQ-029 MAX_HOLD = 4, req = 8'h01 held for 20 cycles -> owner 0 held continuously and preempt never pulses. Then req = 8'h05 -> preempt on the next cycle, then grant_idx = 2.
REQ-030 rst asserted while owner 5 is BUSY -> next cycle all outputs are zero. After release with req = 8'hFF -> grant_idx = 0.
REQ-031 Random req over 10k cycles -> grant is never multi-hot and every held request is granted within 8*(MAX_HOLD+1) cycles.
